// File: rtl/dqs_train_pkg.sv
// Shared state encoding, error codes and busy decode for the DQS eye training sequencer.
package dqs_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_MOVE,
    ST_MOVE_WAIT,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_STEPS = 2'b10;
  localparam logic [1:0] ERR_NOEYE = 2'b11;

  function automatic logic is_busy(input state_t s);
    return (s inside {ST_LOAD, ST_CLEAR, ST_SETTLE, ST_SAMPLE, ST_MOVE, ST_MOVE_WAIT});
  endfunction

endpackage

// File: rtl/dqs_train_timer.sv
// Loadable down-counter shared by the settle and move-wait intervals; expire is high while the count is zero.
// A load value of N gives N+1 cycles of wait with expire asserted in the last one.
module dqs_train_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/dqs_eye_train_ctrl.sv
// Per-lane DQS read-capture training: walks the IOD RX delay from eye-monitor flags until centred.
// All outputs registered off the next-state decode; START ignored while busy, ABORT overrides everything.
module dqs_eye_train_ctrl
  import dqs_train_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_TARGET = 4,
  parameter int MAX_STEPS     = 255,
  parameter int TAP_W         = 8
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       ERROR,
  output logic [TAP_W-1:0] TAP_OFFSET,
  output logic [TAP_W-1:0] STEP_COUNT
);

  localparam int TMR_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STB_W = $clog2(STABLE_TARGET + 1);

  state_t           state, state_nxt;
  logic             tmr_load, tmr_expire;
  logic [TMR_W-1:0] tmr_val;
  logic             cnt_clr, step_en, stb_inc, dir_upd, dir_nxt;
  logic [1:0]       err_nxt;
  logic [STB_W-1:0] stable_cnt;
  logic             at_limit;

  assign at_limit = (STEP_COUNT == TAP_W'(MAX_STEPS));

  dqs_train_timer #(.CNT_W(TMR_W)) u_timer (
    .clk      (FAB_CLK),
    .rst_n    (ARST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    cnt_clr   = 1'b0;
    step_en   = 1'b0;
    stb_inc   = 1'b0;
    dir_upd   = 1'b0;
    dir_nxt   = DELAY_LINE_DIRECTION;
    err_nxt   = ERROR;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (START) begin
          state_nxt = ST_LOAD;
          cnt_clr   = 1'b1;
          err_nxt   = ERR_NONE;
        end
      end
      ST_LOAD: state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        state_nxt = ST_SETTLE;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: if (tmr_expire) state_nxt = ST_SAMPLE;
      ST_SAMPLE: begin
        case ({EYE_MONITOR_EARLY, EYE_MONITOR_LATE})
          2'b10, 2'b01: begin
            state_nxt = ST_MOVE;
            dir_upd   = 1'b1;
            dir_nxt   = EYE_MONITOR_EARLY;
          end
          2'b00: begin
            stb_inc   = 1'b1;
            state_nxt = (stable_cnt == STB_W'(STABLE_TARGET - 1)) ? ST_DONE : ST_CLEAR;
          end
          default: begin
            state_nxt = ST_FAIL;
            err_nxt   = ERR_NOEYE;
          end
        endcase
      end
      ST_MOVE: begin
        if (at_limit) begin
          state_nxt = ST_FAIL;
          err_nxt   = ERR_STEPS;
        end else begin
          state_nxt = ST_MOVE_WAIT;
          step_en   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(1);
        end
      end
      // range flag is only trusted once the delay line has had two cycles to respond
      ST_MOVE_WAIT: begin
        if (tmr_expire) begin
          if (DELAY_LINE_OUT_OF_RANGE) begin
            state_nxt = ST_FAIL;
            err_nxt   = ERR_RANGE;
          end else begin
            state_nxt = ST_CLEAR;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (ABORT) begin
      state_nxt = ST_IDLE;
      tmr_load  = 1'b0;
      cnt_clr   = 1'b0;
      step_en   = 1'b0;
      stb_inc   = 1'b0;
      dir_upd   = 1'b0;
      err_nxt   = ERR_NONE;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                   <= ST_IDLE;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      BUSY                    <= 1'b0;
      DONE                    <= 1'b0;
      ERROR                   <= ERR_NONE;
      TAP_OFFSET              <= '0;
      STEP_COUNT              <= '0;
      stable_cnt              <= '0;
    end else begin
      state                   <= state_nxt;
      DELAY_LINE_LOAD         <= (state_nxt == ST_LOAD);
      EYE_MONITOR_CLEAR_FLAGS <= (state_nxt == ST_CLEAR);
      DELAY_LINE_MOVE         <= (state_nxt == ST_MOVE) && !at_limit;
      BUSY                    <= is_busy(state_nxt);
      DONE                    <= (state_nxt == ST_DONE);
      ERROR                   <= err_nxt;
      if (dir_upd) DELAY_LINE_DIRECTION <= dir_nxt;
      if (cnt_clr) begin
        TAP_OFFSET <= '0;
        STEP_COUNT <= '0;
        stable_cnt <= '0;
      end else if (step_en) begin
        STEP_COUNT <= STEP_COUNT + TAP_W'(1);
        TAP_OFFSET <= DELAY_LINE_DIRECTION ? TAP_OFFSET + TAP_W'(1) : TAP_OFFSET - TAP_W'(1);
        stable_cnt <= '0;
      end else if (stb_inc) begin
        stable_cnt <= stable_cnt + STB_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dqs_eye_train_ctrl.sv
// Scoreboard bench for dqs_eye_train_ctrl: expected pulse/terminal timeline is queued per run and popped as the DUT emits events.
module tb_dqs_eye_train_ctrl;

  localparam int SETTLE = 16;
  localparam int STABLE = 4;
  localparam int MAXST  = 8;
  localparam int TW     = 8;
  localparam int BUDGET = 400;

  localparam logic [3:0] K_LOAD = 4'd1;
  localparam logic [3:0] K_CLR  = 4'd2;
  localparam logic [3:0] K_MOVE = 4'd3;
  localparam logic [3:0] K_DONE = 4'd4;
  localparam logic [3:0] K_FAIL = 4'd5;

  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] cyc;
    logic        dir;
    logic [1:0]  err;
    logic [7:0]  tap;
    logic [7:0]  step;
  } evt_t;

  logic FAB_CLK = 1'b0;
  logic ARST_N = 1'b1;
  logic START = 1'b0;
  logic ABORT = 1'b0;
  logic EYE_MONITOR_EARLY = 1'b0;
  logic EYE_MONITOR_LATE = 1'b0;
  logic DELAY_LINE_OUT_OF_RANGE = 1'b0;
  logic DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS;
  logic BUSY, DONE;
  logic [1:0] ERROR;
  logic [TW-1:0] TAP_OFFSET, STEP_COUNT;

  int n_checks = 0;
  int n_fail = 0;
  evt_t sb_q[$];

  always #5 FAB_CLK = ~FAB_CLK;

  dqs_eye_train_ctrl #(
    .SETTLE_CYCLES(SETTLE), .STABLE_TARGET(STABLE), .MAX_STEPS(MAXST), .TAP_W(TW)
  ) dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .START(START), .ABORT(ABORT),
    .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY), .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .TAP_OFFSET(TAP_OFFSET), .STEP_COUNT(STEP_COUNT)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic evt_t mk(input logic [3:0] k, input int c, input logic d,
                              input logic [1:0] e, input logic [7:0] t, input logic [7:0] s);
    evt_t v;
    v.kind = k; v.cyc = c[15:0]; v.dir = d; v.err = e; v.tap = t; v.step = s;
    return v;
  endfunction

  // Timeline model: CLEAR, SETTLE cycles, one SAMPLE; a move costs MOVE + 2 wait cycles before the next CLEAR.
  task automatic build_expect(input logic [1:0] pat_a, input int n_a, input logic [1:0] pat_b, input int oor_mv);
    int clr, s, k, stb, steps;
    logic [7:0] tap;
    logic [1:0] f;
    bit fin;
    sb_q.delete();
    sb_q.push_back(mk(K_LOAD, 1, 1'b0, 2'b00, 8'd0, 8'd0));
    sb_q.push_back(mk(K_CLR, 2, 1'b0, 2'b00, 8'd0, 8'd0));
    clr = 2; k = 0; stb = 0; steps = 0; tap = 8'd0; fin = 1'b0;
    while (!fin) begin
      s = clr + 1 + SETTLE;
      f = (k < n_a) ? pat_a : pat_b;
      k++;
      if (f == 2'b00) begin
        stb++;
        if (stb == STABLE) begin
          sb_q.push_back(mk(K_DONE, s + 1, 1'b0, 2'b00, tap, steps[7:0]));
          fin = 1'b1;
        end else begin
          clr = s + 1;
          sb_q.push_back(mk(K_CLR, clr, 1'b0, 2'b00, 8'd0, 8'd0));
        end
      end else if (f == 2'b11) begin
        sb_q.push_back(mk(K_FAIL, s + 1, 1'b0, 2'b11, tap, steps[7:0]));
        fin = 1'b1;
      end else if (steps == MAXST) begin
        sb_q.push_back(mk(K_FAIL, s + 2, 1'b0, 2'b10, tap, steps[7:0]));
        fin = 1'b1;
      end else begin
        sb_q.push_back(mk(K_MOVE, s + 1, f[1], 2'b00, 8'd0, 8'd0));
        steps++;
        tap = f[1] ? tap + 8'd1 : tap - 8'd1;
        stb = 0;
        if (steps == oor_mv) begin
          sb_q.push_back(mk(K_FAIL, s + 4, 1'b0, 2'b01, tap, steps[7:0]));
          fin = 1'b1;
        end else begin
          clr = s + 4;
          sb_q.push_back(mk(K_CLR, clr, 1'b0, 2'b00, 8'd0, 8'd0));
        end
      end
    end
  endtask

  task automatic run_scn(input string name, input logic [1:0] pat_a, input int n_a,
                         input logic [1:0] pat_b, input int oor_mv);
    int nclr, nmv, npulse;
    bit fin;
    evt_t e, term;
    logic [3:0] kind;
    build_expect(pat_a, n_a, pat_b, oor_mv);
    nclr = 0; nmv = 0; fin = 1'b0; term = '0;
    {EYE_MONITOR_EARLY, EYE_MONITOR_LATE} = (n_a > 0) ? pat_a : pat_b;
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    @(negedge FAB_CLK);
    START = 1'b1;
    @(posedge FAB_CLK);
    #1 START = 1'b0;
    for (int cyc = 1; cyc <= BUDGET && !fin; cyc++) begin
      @(negedge FAB_CLK);
      check_val({name, ":excl"},
                32'(int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS) <= 1), 32'd1);
      kind = 4'd0;
      if (DELAY_LINE_LOAD) kind = K_LOAD;
      else if (EYE_MONITOR_CLEAR_FLAGS) begin
        kind = K_CLR;
        nclr++;
        {EYE_MONITOR_EARLY, EYE_MONITOR_LATE} = (nclr - 1 < n_a) ? pat_a : pat_b;
      end else if (DELAY_LINE_MOVE) begin
        kind = K_MOVE;
        nmv++;
        if (nmv == oor_mv) DELAY_LINE_OUT_OF_RANGE = 1'b1;
      end else if (DONE || ERROR != 2'b00) begin
        kind = DONE ? K_DONE : K_FAIL;
        fin = 1'b1;
      end
      if (kind != 4'd0) begin
        if (sb_q.size() == 0) check_val({name, ":unexpected"}, 32'(kind), 32'd0);
        else begin
          e = sb_q.pop_front();
          check_val({name, ":kind"}, 32'(kind), 32'(e.kind));
          check_val({name, ":cycle"}, cyc, 32'(e.cyc));
          if (kind == K_MOVE) check_val({name, ":dir"}, 32'(DELAY_LINE_DIRECTION), 32'(e.dir));
          if (fin) begin
            term = e;
            check_val({name, ":err"}, 32'(ERROR), 32'(e.err));
            check_val({name, ":tap"}, 32'(TAP_OFFSET), 32'(e.tap));
            check_val({name, ":step"}, 32'(STEP_COUNT), 32'(e.step));
            check_val({name, ":busy"}, 32'(BUSY), 32'd0);
          end
        end
      end
    end
    if (!fin) check_val({name, ":timeout"}, 32'd0, 32'd1);
    check_val({name, ":sb_left"}, sb_q.size(), 32'd0);
    npulse = 0;
    repeat (3) begin
      @(negedge FAB_CLK);
      npulse += int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS);
    end
    check_val({name, ":hold_pulses"}, npulse, 32'd0);
    check_val({name, ":hold_done"}, 32'(DONE), 32'(term.kind == K_DONE));
    check_val({name, ":hold_err"}, 32'(ERROR), 32'(term.err));
    check_val({name, ":hold_tap"}, 32'(TAP_OFFSET), 32'(term.tap));
    {EYE_MONITOR_EARLY, EYE_MONITOR_LATE} = 2'b00;
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
  endtask

  initial begin
    int npulse;
    #1 ARST_N = 1'b0;
    #12;
    check_val("rst_load", 32'(DELAY_LINE_LOAD), 32'd0);
    check_val("rst_move", 32'(DELAY_LINE_MOVE), 32'd0);
    check_val("rst_dir", 32'(DELAY_LINE_DIRECTION), 32'd0);
    check_val("rst_clr", 32'(EYE_MONITOR_CLEAR_FLAGS), 32'd0);
    check_val("rst_busy", 32'(BUSY), 32'd0);
    check_val("rst_done", 32'(DONE), 32'd0);
    check_val("rst_err", 32'(ERROR), 32'd0);
    check_val("rst_tap", 32'(TAP_OFFSET), 32'd0);
    check_val("rst_step", 32'(STEP_COUNT), 32'd0);
    @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);

    run_scn("centred", 2'b00, 0, 2'b00, 0);
    run_scn("early3", 2'b10, 3, 2'b00, 0);
    run_scn("late_oor", 2'b01, 0, 2'b01, 5);
    run_scn("step_lim", 2'b10, 0, 2'b10, 0);
    run_scn("no_eye", 2'b11, 1, 2'b00, 0);

    // abort during the second settle, one move already made
    EYE_MONITOR_EARLY = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b1;
    @(posedge FAB_CLK);
    #1 START = 1'b0;
    for (int c = 1; c <= 29; c++) begin
      @(negedge FAB_CLK);
      if (c == 20) EYE_MONITOR_EARLY = 1'b0;
    end
    check_val("abort_pre_busy", 32'(BUSY), 32'd1);
    check_val("abort_pre_step", 32'(STEP_COUNT), 32'd1);
    ABORT = 1'b1;
    START = 1'b1;
    @(posedge FAB_CLK);
    #1 begin ABORT = 1'b0; START = 1'b0; end
    @(negedge FAB_CLK);
    check_val("abort_busy", 32'(BUSY), 32'd0);
    check_val("abort_done", 32'(DONE), 32'd0);
    check_val("abort_err", 32'(ERROR), 32'd0);
    check_val("abort_tap_kept", 32'(TAP_OFFSET), 32'd1);
    check_val("abort_step_kept", 32'(STEP_COUNT), 32'd1);
    npulse = 0;
    repeat (20) begin
      @(negedge FAB_CLK);
      npulse += int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS) + int'(BUSY);
    end
    check_val("abort_quiet", npulse, 32'd0);
    START = 1'b1;
    @(posedge FAB_CLK);
    #1 START = 1'b0;
    @(negedge FAB_CLK);
    check_val("restart_load", 32'(DELAY_LINE_LOAD), 32'd1);
    check_val("restart_tap", 32'(TAP_OFFSET), 32'd0);
    check_val("restart_step", 32'(STEP_COUNT), 32'd0);
    ABORT = 1'b1;
    @(posedge FAB_CLK);
    #1 ABORT = 1'b0;

    // asynchronous reset in MOVE_WAIT after one upward step
    EYE_MONITOR_EARLY = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b1;
    @(posedge FAB_CLK);
    #1 START = 1'b0;
    repeat (21) @(negedge FAB_CLK);
    check_val("arst_pre_dir", 32'(DELAY_LINE_DIRECTION), 32'd1);
    check_val("arst_pre_step", 32'(STEP_COUNT), 32'd1);
    #2 ARST_N = 1'b0;
    #1;
    check_val("arst_busy", 32'(BUSY), 32'd0);
    check_val("arst_dir", 32'(DELAY_LINE_DIRECTION), 32'd0);
    check_val("arst_tap", 32'(TAP_OFFSET), 32'd0);
    check_val("arst_step", 32'(STEP_COUNT), 32'd0);
    npulse = 0;
    repeat (3) begin
      @(negedge FAB_CLK);
      npulse += int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS);
    end
    check_val("arst_quiet", npulse, 32'd0);
    EYE_MONITOR_EARLY = 1'b0;
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
